// File: rtl/prog_sequencer.sv
// Launches NPROG programs back-to-back through the PC Start handshake and waits
// for the core's Done after each. Captures per-program run length and aborts on timeout.
module prog_sequencer #(
    parameter int NPROG     = 3,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 1000,
    parameter int TW        = 16,
    localparam int IW       = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Done,
    output logic          Start,
    output logic [IW-1:0] ProgIdx,
    output logic          Busy,
    output logic          AllDone,
    output logic          Timeout,
    output logic [TW-1:0] RunCycles
);

    localparam int SW = $clog2(START_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NPROG - 1);
    localparam logic [SW-1:0] START_LAST  = SW'(START_CYC);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);

    generate
        if (START_CYC < 1) begin : g_bad_start_cyc
            $error("prog_sequencer: START_CYC must be >= 1");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout_low
            $error("prog_sequencer: TIMEOUT must be >= 2");
        end
        if ((TW < 31) && (TIMEOUT >= (1 << TW))) begin : g_bad_timeout_high
            $error("prog_sequencer: TIMEOUT must be < 2**TW");
        end
        if (NPROG < 1) begin : g_bad_nprog
            $error("prog_sequencer: NPROG must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t        state_r;
    logic [SW-1:0] start_cnt_r;
    logic [TW-1:0] cyc_cnt_r;
    logic [TW-1:0] cyc_inc_s;
    logic          start_r;
    logic [IW-1:0] prog_idx_r;
    logic          busy_r;
    logic          all_done_r;
    logic          timeout_r;
    logic [TW-1:0] run_cycles_r;

    // cyc_cnt_r holds completed RUN cycles, so the current cycle's count is one more
    always_comb begin
        cyc_inc_s = cyc_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= S_IDLE;
            start_cnt_r  <= {SW{1'b0}};
            cyc_cnt_r    <= {TW{1'b0}};
            start_r      <= 1'b0;
            prog_idx_r   <= {IW{1'b0}};
            busy_r       <= 1'b0;
            all_done_r   <= 1'b0;
            timeout_r    <= 1'b0;
            run_cycles_r <= {TW{1'b0}};
        end else begin
            all_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (Go) begin
                        state_r     <= S_LAUNCH;
                        prog_idx_r  <= {IW{1'b0}};
                        timeout_r   <= 1'b0;
                        start_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        start_cnt_r <= {{(SW-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    // start_cnt_r counts Start-high cycles already committed
                    if (start_cnt_r == START_LAST) begin
                        start_r   <= 1'b0;
                        cyc_cnt_r <= {TW{1'b0}};
                        state_r   <= S_RUN;
                    end else begin
                        start_cnt_r <= start_cnt_r + {{(SW-1){1'b0}}, 1'b1};
                    end
                end
                S_RUN: begin
                    if (Done) begin
                        run_cycles_r <= cyc_inc_s;
                        state_r      <= S_NEXT;
                    end else if (cyc_inc_s == TIMEOUT_VAL) begin
                        timeout_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= S_IDLE;
                    end else begin
                        cyc_cnt_r <= cyc_inc_s;
                    end
                end
                S_NEXT: begin
                    if (prog_idx_r == LAST_IDX) begin
                        all_done_r <= 1'b1;
                        state_r    <= S_FINISH;
                    end else begin
                        prog_idx_r  <= prog_idx_r + {{(IW-1){1'b0}}, 1'b1};
                        start_r     <= 1'b1;
                        start_cnt_r <= {{(SW-1){1'b0}}, 1'b1};
                        state_r     <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Start     = start_r;
    assign ProgIdx   = prog_idx_r;
    assign Busy      = busy_r;
    assign AllDone   = all_done_r;
    assign Timeout   = timeout_r;
    assign RunCycles = run_cycles_r;

endmodule
